// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/decode unit:
// FSM state encoding, instruction field bit positions and IR reset value.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  localparam int TYPE_MSB = 31;
  localparam int TYPE_LSB = 29;
  localparam int OP_MSB   = 28;
  localparam int OP_LSB   = 24;
  localparam int RC_MSB   = 23;
  localparam int RC_LSB   = 20;
  localparam int RA_MSB   = 19;
  localparam int RA_LSB   = 16;
  localparam int RB_MSB   = 15;
  localparam int RB_LSB   = 12;
  localparam int IMM_MSB  = 15;
  localparam int IMM_LSB  = 0;

  localparam logic [31:0] IR_RESET = 32'h0;

endpackage

// File: rtl/instr_fetch_decode.sv
// Instruction fetch and field decode: owns PC and IR, runs a req/ack read of
// instruction memory on the control unit's fetch strobe, and slices IR fields.
module instr_fetch_decode
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               W_IM,
  input  logic               W_PC,
  input  logic               S_MXPC,
  input  logic [PC_W-1:0]    TARGET,
  output logic               IM_REQ,
  output logic [PC_W-1:0]    IM_ADDR,
  input  logic               IM_ACK,
  input  logic [31:0]        IM_RDATA,
  output logic [PC_W-1:0]    PC,
  output logic               IR_VALID,
  output logic               BUSY,
  output logic               OVERRUN,
  output logic [2:0]         TYPE,
  output logic [4:0]         op,
  output logic [3:0]         RC,
  output logic [3:0]         RA,
  output logic [3:0]         RB,
  output logic [15:0]        IMM,
  output fetch_state_e       STATE
);

  // Handshake: IM_REQ rises the cycle after W_IM and IM_ADDR stays frozen
  // until the edge where IM_ACK is sampled high; that edge loads IR and drops
  // IM_REQ. ACK outside REQ is ignored; memory must tolerate abandoned requests.

  fetch_state_e    r_state;
  fetch_state_e    w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_addr;
  logic [31:0]     r_ir;
  logic            r_ir_valid;
  logic            r_overrun;

  logic            w_start;
  logic            w_load;
  logic            w_overrun_set;
  logic [PC_W-1:0] w_next_pc;

  always_comb begin
    w_next_state  = r_state;
    w_start       = 1'b0;
    w_load        = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (W_IM) begin
          w_next_state = ST_REQ;
          w_start      = 1'b1;
        end
      end
      ST_REQ: begin
        w_overrun_set = W_IM;
        if (IM_ACK) begin
          w_next_state = ST_HOLD;
          w_load       = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_next_pc = S_MXPC ? TARGET : (r_pc + PC_W'(1));

  // IM_ADDR samples the pre-update PC, so a same-cycle W_PC never redirects a fetch.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_addr     <= RESET_PC;
      r_ir       <= IR_RESET;
      r_ir_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_addr     <= r_pc;
        r_ir_valid <= 1'b0;
      end
      if (w_load) begin
        r_ir       <= IM_RDATA;
        r_ir_valid <= 1'b1;
      end
      if (W_PC)
        r_pc <= w_next_pc;
      if (w_overrun_set)
        r_overrun <= 1'b1;
    end
  end

  assign IM_REQ   = (r_state == ST_REQ);
  assign BUSY     = IM_REQ;
  assign IM_ADDR  = r_addr;
  assign PC       = r_pc;
  assign IR_VALID = r_ir_valid;
  assign OVERRUN  = r_overrun;
  assign STATE    = r_state;

  assign TYPE = r_ir[TYPE_MSB:TYPE_LSB];
  assign op   = r_ir[OP_MSB:OP_LSB];
  assign RC   = r_ir[RC_MSB:RC_LSB];
  assign RA   = r_ir[RA_MSB:RA_LSB];
  assign RB   = r_ir[RB_MSB:RB_LSB];
  assign IMM  = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed and randomized checks of instr_fetch_decode against a
// transaction-level model of PC, pending fetch and instruction register.
module tb_instr_fetch_decode;
  import fetch_pkg::*;

  localparam int          PC_W     = 16;
  localparam logic [15:0] RST_PC   = 16'h0010;

  logic        CLK = 1'b0;
  logic        RST_N, W_IM, W_PC, S_MXPC, IM_ACK;
  logic [15:0] TARGET;
  logic [31:0] IM_RDATA;
  logic        IM_REQ, IR_VALID, BUSY, OVERRUN;
  logic [15:0] IM_ADDR, PC;
  logic [2:0]  TYPE;
  logic [4:0]  op;
  logic [3:0]  RC, RA, RB;
  logic [15:0] IMM;
  fetch_state_e STATE;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a fetch is either pending at some address or not.
  bit          m_pending;
  logic [15:0] m_addr;
  logic [15:0] m_pc;
  logic [31:0] m_ir;
  bit          m_ir_valid;
  bit          m_overrun;

  instr_fetch_decode #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RST_N(RST_N), .W_IM(W_IM), .W_PC(W_PC), .S_MXPC(S_MXPC),
    .TARGET(TARGET), .IM_REQ(IM_REQ), .IM_ADDR(IM_ADDR), .IM_ACK(IM_ACK),
    .IM_RDATA(IM_RDATA), .PC(PC), .IR_VALID(IR_VALID), .BUSY(BUSY),
    .OVERRUN(OVERRUN), .TYPE(TYPE), .op(op), .RC(RC), .RA(RA), .RB(RB),
    .IMM(IMM), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies the behavioural rules to the inputs present at this clock edge.
  task automatic model_edge();
    if (!RST_N) begin
      m_pending = 0; m_addr = RST_PC; m_pc = RST_PC;
      m_ir = 32'h0; m_ir_valid = 0; m_overrun = 0;
    end else begin
      if (m_pending) begin
        if (W_IM) m_overrun = 1;
        if (IM_ACK) begin
          m_ir = IM_RDATA; m_ir_valid = 1; m_pending = 0;
        end
      end else if (W_IM) begin
        m_pending = 1; m_addr = m_pc; m_ir_valid = 0;
      end
      if (W_PC) m_pc = S_MXPC ? TARGET : m_pc + 16'd1;
    end
  endtask

  task automatic check_all();
    logic [1:0] exp_state;
    exp_state = m_pending ? 2'd1 : (m_ir_valid ? 2'd2 : 2'd0);
    check("pc", 32'(PC), 32'(m_pc));
    check("im_req", 32'(IM_REQ), 32'(m_pending));
    check("busy", 32'(BUSY), 32'(m_pending));
    check("im_addr", 32'(IM_ADDR), 32'(m_addr));
    check("ir_valid", 32'(IR_VALID), 32'(m_ir_valid));
    check("overrun", 32'(OVERRUN), 32'(m_overrun));
    check("fields_hi", 32'({TYPE, op, RC, RA, RB}), 32'(m_ir[31:12]));
    check("imm", 32'(IMM), 32'(m_ir[15:0]));
    check("state", 32'(STATE), 32'(exp_state));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    W_IM = 0; W_PC = 0; S_MXPC = 0; TARGET = 16'h0; IM_ACK = 0; IM_RDATA = 32'h0;
  endtask

  initial begin
    RST_N = 0;
    idle_inputs();

    // Reset values
    step();
    check("rst_pc", 32'(PC), 32'h0010);
    check("rst_addr", 32'(IM_ADDR), 32'h0010);
    check("rst_req", 32'(IM_REQ), 32'h0);
    check("rst_ir", 32'({TYPE, op, RC, RA, RB, IMM}), 32'h0);

    // Zero-wait fetch
    RST_N = 1; W_IM = 1;
    step();
    check("f1_req", 32'(IM_REQ), 32'h1);
    check("f1_addr", 32'(IM_ADDR), 32'h0010);
    check("f1_irv", 32'(IR_VALID), 32'h0);
    W_IM = 0; IM_ACK = 1; IM_RDATA = 32'h2A31_2345;
    step();
    check("f1_type", 32'(TYPE), 32'h1);
    check("f1_op", 32'(op), 32'h0A);
    check("f1_rc", 32'(RC), 32'h3);
    check("f1_ra", 32'(RA), 32'h1);
    check("f1_rb", 32'(RB), 32'h2);
    check("f1_imm", 32'(IMM), 32'h2345);
    check("f1_irv", 32'(IR_VALID), 32'h1);
    check("f1_req_drop", 32'(IM_REQ), 32'h0);

    // Five-cycle ACK delay
    IM_ACK = 0; W_IM = 1;
    step();
    W_IM = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("wait_req", 32'({IM_REQ, BUSY}), 32'h3);
      check("wait_addr", 32'(IM_ADDR), 32'h0010);
      check("wait_irv", 32'(IR_VALID), 32'h0);
    end
    IM_ACK = 1; IM_RDATA = 32'h1234_5678;
    step();
    check("wait_done", 32'(IR_VALID), 32'h1);
    IM_ACK = 0;

    // PC wrap and target load
    W_PC = 1; S_MXPC = 1; TARGET = 16'hFFFF;
    step();
    check("pc_ffff", 32'(PC), 32'hFFFF);
    S_MXPC = 0;
    step();
    check("pc_wrap", 32'(PC), 32'h0000);
    S_MXPC = 1; TARGET = 16'h1234;
    step();
    check("pc_tgt", 32'(PC), 32'h1234);

    // Same-cycle W_PC and W_IM: fetch uses the old PC
    TARGET = 16'h0004;
    step();
    W_IM = 1; TARGET = 16'h0800;
    step();
    check("same_addr", 32'(IM_ADDR), 32'h0004);
    check("same_pc", 32'(PC), 32'h0800);
    W_IM = 0; W_PC = 0; IM_ACK = 1; IM_RDATA = 32'hDEAD_BEEF;
    step();
    IM_ACK = 0;

    // Overrun while in flight and on the ACK cycle
    W_IM = 1;
    step();
    step();
    check("ovr_set", 32'(OVERRUN), 32'h1);
    IM_ACK = 1; IM_RDATA = 32'hCAFE_0001;
    step();
    W_IM = 0; IM_ACK = 0;
    step();
    check("ovr_sticky", 32'(OVERRUN), 32'h1);
    check("ovr_hold", 32'(STATE), 32'(ST_HOLD));
    check("ovr_noreq", 32'(IM_REQ), 32'h0);

    // Reset mid-request, then a late ACK
    W_IM = 1;
    step();
    W_IM = 0; RST_N = 0;
    step();
    check("rr_req", 32'(IM_REQ), 32'h0);
    check("rr_pc", 32'(PC), 32'h0010);
    check("rr_irv", 32'(IR_VALID), 32'h0);
    check("rr_ovr", 32'(OVERRUN), 32'h0);
    RST_N = 1; IM_ACK = 1; IM_RDATA = 32'hFFFF_FFFF;
    step();
    check("late_ack", 32'({IR_VALID, IMM}), 32'h0);
    check("late_state", 32'(STATE), 32'(ST_IDLE));

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      RST_N    = ($urandom_range(0, 59) != 0);
      W_IM     = ($urandom_range(0, 3) == 0);
      W_PC     = ($urandom_range(0, 3) == 0);
      S_MXPC   = $urandom_range(0, 1);
      TARGET   = 16'($urandom);
      IM_ACK   = ($urandom_range(0, 2) == 0);
      IM_RDATA = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Instruction fetch and field-decode unit that answers the processor's multi-cycle control unit. It consumes the control unit's fetch strobe (`W_IM`), PC write strobe (`W_PC`) and PC source select (`S_MXPC`). It owns the program counter and the instruction register, and runs a request/acknowledge read of instruction memory. It returns the decoded `type`/`op` fields, which feed back into the control unit, plus the register and immediate fields for the datapath.

## Interface
- `PC_W`, 16, program counter / instruction address width
- `RESET_PC`, 0, PC value after reset

- `CLK`  in  1  system clock, all state on rising edge
- `RST_N`  in  1  synchronous reset, active low
- `W_IM`  in  1  fetch strobe from control unit (one-cycle pulse)
- `W_PC`  in  1  PC write strobe from control unit
- `S_MXPC`  in  1  PC source: 0 = PC+1, 1 = `TARGET`
- `TARGET`  in  PC_W  branch/jump target from datapath
- `IM_REQ`  out  1  instruction memory read request
- `IM_ADDR`  out  PC_W  instruction memory address
- `IM_ACK`  in  1  memory acknowledge, `IM_RDATA` valid
- `IM_RDATA`  in  32  instruction word
- `PC`  out  PC_W  current program counter
- `IR_VALID`  out  1  instruction register holds a fetched word
- `BUSY`  out  1  fetch in flight (state REQ)
- `OVERRUN`  out  1  sticky: `W_IM` arrived while a fetch was in flight
- `type`  out  3  IR[31:29]
- `op`  out  5  IR[28:24]
- `RC`  out  4  IR[23:20], destination register
- `RA`  out  4  IR[19:16]
- `RB`  out  4  IR[15:12]
- `IMM`  out  16  IR[15:0], raw; sign extension happens downstream

## Operation
- States:
  - IDLE: reset state, no valid IR.
  - REQ: request outstanding.
  - HOLD: IR valid, waiting for the next `W_IM`.
- Transitions:
  - IDLE/HOLD + `W_IM` → REQ. On entry, `IM_ADDR` <= `PC`.
  - REQ + `IM_ACK` → HOLD. On that edge, IR <= `IM_RDATA` and `IR_VALID` <= 1.
  - REQ without `IM_ACK` → stay in REQ, holding `IM_REQ`/`IM_ADDR` stable.
- `IM_REQ` = (state == REQ), registered. `BUSY` = `IM_REQ`.
- `IR_VALID` clears on entry to REQ. It is never set in IDLE.
- `W_IM` in REQ, including the cycle `IM_ACK` is high, is ignored for fetch purposes and sets `OVERRUN`. `OVERRUN` clears only on reset.
- `W_PC`, in any state: PC <= `S_MXPC` ? `TARGET` : PC + 1, modulo 2^PC_W. PC = 2^PC_W−1 with PC+1 wraps to 0.
- `W_PC` during REQ updates PC only. The in-flight `IM_ADDR` is unchanged.
- `W_PC` and `W_IM` in the same cycle: the fetch uses the old PC, because `IM_ADDR` samples PC before update.
- Decoded fields are continuous slices of IR and change only when IR is loaded.
- The control unit treats `type`/`op` as meaningful only while `IR_VALID` = 1.

## Timing
- Reset (`RST_N` = 0 at an edge) gives:
  - state IDLE, PC = `RESET_PC`, `IM_ADDR` = `RESET_PC`
  - `IM_REQ` = 0, `IR_VALID` = 0, `OVERRUN` = 0
  - IR = 0, so `type`/`op`/`RC`/`RA`/`RB`/`IMM` = 0
- Reset during REQ abandons the request: `IM_REQ` is 0 the cycle after. Memory must tolerate abandoned requests.
- `W_IM` sampled at edge n → `IM_REQ` = 1 and `IM_ADDR` valid after edge n.
- `IM_ACK` sampled at edge m (m ≥ n+1) → IR, fields and `IR_VALID` = 1 after edge m, with `IM_REQ` = 0 in the same cycle.
- Minimum fetch latency is 2 edges from `W_IM` to valid fields (zero-wait memory acknowledging in the first REQ cycle).
- `IM_ACK` outside REQ is ignored.
- `W_PC` sampled at edge k → new `PC` visible after edge k.

## Structure
- `fetch_pkg`:
  - state enum (IDLE, REQ, HOLD)
  - field bit-position constants for type, op, RC, RA, RB, IMM
  - `IR_RESET` = 32'h0
- Single flat module, with no sub-module. The next-PC mux and incrementer are inline.

## Test plan
- Reset with `RESET_PC`=0x0010, then `W_IM` pulse; memory ACKs next cycle with 0x2A31_2345 → `IM_ADDR`=0x0010, then `type`=3'b001, `op`=5'b01010, `RC`=3, `RA`=1, `RB`=2, `IMM`=0x2345, `IR_VALID`=1.
- Memory delays `IM_ACK` by 5 cycles → `IM_REQ`, `IM_ADDR` and `BUSY` are stable for all 5 cycles, and `IR_VALID`=0 until the ACK edge.
- PC=0xFFFF, `W_PC` with `S_MXPC`=0 → PC=0x0000. Then `W_PC` with `S_MXPC`=1 and `TARGET`=0x1234 → PC=0x1234.
- `W_PC` (`S_MXPC`=1, `TARGET`=0x0800) issued in the same cycle as `W_IM` while PC=0x0004 → `IM_ADDR`=0x0004 and PC=0x0800.
- Second `W_IM` during an outstanding fetch, and again on the ACK cycle → `OVERRUN`=1 and remains 1. Only one fetch is completed, and the state ends in HOLD.
- `RST_N` low for one cycle mid-REQ → next cycle `IM_REQ`=0, PC=`RESET_PC`, `IR_VALID`=0, `OVERRUN`=0. A late `IM_ACK` is ignored.
